c3lib_ckdiv_prog: RTL
=====================

// Module: c3lib_ckdiv_prog
// PURPOSE
//   Programmable integer clock divider producing a flop-driven, glitch-free divided
//   clock for downstream clock inverters/buffers in the clock tree. Ratio changes
//   use a 4-phase req/ack handshake and apply only at a period boundary. An enable
//   parks the output low cleanly so downstream clock cells never see runt pulses.
// PARAMETERS
//   RATIO_W    4   width of the divide-ratio bus; max ratio = 2**RATIO_W-1
//   DEF_RATIO  2   ratio loaded at reset; must be in 2..2**RATIO_W-1
// PORTS
//   clk_in      in   1        source clock; all logic on rising edge
//   rst_n       in   1        async active-low reset; synchronous deassertion by integrator
//   div_en      in   1        1 = run divider; 0 = park clk_out low at period end
//   ratio_in    in   RATIO_W  requested divide ratio; held stable while ratio_req=1
//   ratio_req   in   1        4-phase request to load ratio_in
//   ratio_ack   out  1        4-phase acknowledge
//   ratio_cur   out  RATIO_W  ratio currently in effect
//   clk_out     out  1        divided clock, direct flop output
//   div_sync    out  1        1-cycle pulse aligned with each clk_out rising edge
//   div_active  out  1        1 while FSM is in RUN or DRAIN
// BEHAVIOUR
//   Reset (async, rst_n=0): clk_out=0, div_sync=0, ratio_ack=0, div_active=0,
//     ratio_cur=DEF_RATIO, cnt=0, FSM=PARKED, no pending request. Applies mid-period.
//   Clamp: ratio_in values 0 and 1 load as 2. No divide-by-1 mode.
//   hi = ceil(ratio_cur/2). Period = ratio_cur clk_in cycles: high hi cycles, then low
//     ratio_cur-hi cycles. Even ratios give 50% duty; odd ratios are high-biased (5 -> 3H/2L).
//   cnt runs 0..ratio_cur-1 in RUN/DRAIN. Registered outputs: clk_out <= (cnt_next < hi);
//     div_sync <= (cnt_next == 0). Boundary = cycle where cnt == ratio_cur-1.
//   FSM:
//     PARKED: clk_out=0, cnt=0. div_en=1 -> RUN; the next edge sets cnt=0, clk_out=1,
//       div_sync=1. Latency from sampled div_en=1 to clk_out rise is 1 clk_in cycle.
//     RUN: count and wrap. div_en=0 sampled -> DRAIN. The current period is not cut.
//     DRAIN: finish the current period. At the boundary go to PARKED with clk_out=0.
//       div_en=1 again during DRAIN -> RUN with no gap in the waveform.
//   Ratio handshake:
//     - ratio_req=1 && ratio_ack=0 && no pending request: capture the clamped ratio_in
//       into pending.
//     - RUN/DRAIN: pending loads into ratio_cur at the next boundary, so the new
//       period starts with the new ratio.
//     - PARKED: pending loads on the cycle after capture.
//     - ratio_ack rises the cycle after ratio_cur updates and holds while ratio_req=1.
//     - ratio_ack falls the cycle after ratio_req=0 is sampled. A new request is
//       accepted only after ratio_ack=0.
//     - Dropping ratio_req before ratio_ack rises is a protocol violation with
//       undefined result. Bench asserts on it.
//   Simultaneous events: at a boundary with both a pending ratio and div_en=0 in DRAIN,
//     the ratio loads and the FSM parks. cnt wrap and ratio load in the same cycle use the
//     new ratio for the next period. div_sync never pulses in PARKED.
//   clk_out has no combinational path from any input.
// TESTING
//   1 Reset, ratio default 2, div_en=1 -> clk_out 1H/1L repeating, div_sync on every rise.
//   2 Load ratio 5 while PARKED, then enable -> ratio_ack rises 2 cycles after req;
//     clk_out 3H/2L, period 5.
//   3 Running at 5, request 4 at cnt=1 -> remaining 3 cycles at ratio 5, then 2H/2L;
//     ack one cycle after the first ratio-4 period starts; ack falls 1 cycle after req drops.
//   4 div_en=0 at cnt=0, ratio 6 -> full 3H/3L completes, then clk_out stays 0,
//     div_active=0, no div_sync pulses.
//   5 ratio_in=0 and ratio_in=1 requests -> ratio_cur=2, output 1H/1L.
//   6 rst_n low mid high phase at ratio 7 -> clk_out=0 immediately, ratio_cur=2,
//     ack=0, PARKED after release.

Source files
------------

// File: rtl/c3lib_ckdiv_prog.sv
// ---------------------------------------------------------------------------
// c3lib_ckdiv_prog
//   Programmable integer clock divider. Produces a flop-driven, glitch-free
//   divided clock whose period is ratio_cur source cycles (high for
//   ceil(ratio_cur/2) cycles, then low). Ratio changes use a 4-phase req/ack
//   handshake and take effect only on a period boundary. Disabling lets the
//   current period finish, then parks clk_out low.
//
// Ports
//   clk_in      source clock, all logic on its rising edge
//   rst_n       async active-low reset
//   div_en      1 = run, 0 = park clk_out low at the end of the current period
//   ratio_in    requested ratio, stable while ratio_req=1 (0/1 load as 2)
//   ratio_req   4-phase request to load ratio_in
//   ratio_ack   4-phase acknowledge
//   ratio_cur   ratio currently in effect
//   clk_out     divided clock, direct flop output
//   div_sync    one-cycle pulse aligned with each clk_out rising edge
//   div_active  1 while the divider is running or draining
// ---------------------------------------------------------------------------
module c3lib_ckdiv_prog #(
  parameter int RATIO_W   = 4,
  parameter int DEF_RATIO = 2
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               div_en,
  input  logic [RATIO_W-1:0] ratio_in,
  input  logic               ratio_req,
  output logic               ratio_ack,
  output logic [RATIO_W-1:0] ratio_cur,
  output logic               clk_out,
  output logic               div_sync,
  output logic               div_active
);

  typedef enum logic [1:0] {
    ST_PARKED = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam logic [RATIO_W-1:0] ONE  = RATIO_W'(1);
  localparam logic [RATIO_W-1:0] TWO  = RATIO_W'(2);
  localparam logic [RATIO_W-1:0] ZERO = RATIO_W'(0);
  localparam logic [RATIO_W-1:0] DEF  = RATIO_W'(DEF_RATIO);

  // There is no divide-by-1 mode: 0 and 1 are promoted to 2.
  function automatic logic [RATIO_W-1:0] clamp_ratio(input logic [RATIO_W-1:0] r);
    if (r < TWO) begin
      return TWO;
    end else begin
      return r;
    end
  endfunction

  // Length of the high phase: ceil(r/2), so odd ratios are high-biased.
  function automatic logic [RATIO_W-1:0] high_len(input logic [RATIO_W-1:0] r);
    return (r >> 1) + {{(RATIO_W-1){1'b0}}, r[0]};
  endfunction

  state_t             state_r, state_next_s;
  logic [RATIO_W-1:0] cnt_r, cnt_next_s;
  logic [RATIO_W-1:0] ratio_cur_r, ratio_next_s;
  logic [RATIO_W-1:0] pend_ratio_r;
  logic               pend_vld_r;
  logic               loaded_r;
  logic               taken_r;
  logic               ratio_ack_r;
  logic               clk_out_r, clk_next_s;
  logic               div_sync_r, sync_next_s;
  logic               div_active_r;
  logic               running_s, boundary_s, period_end_s;
  logic               load_s, capture_s, ack_fall_s;

  // Handshake and boundary decode. taken_r spans capture..ack-fall so a
  // request still held high after its load is not captured a second time.
  always_comb begin
    running_s    = (state_r != ST_PARKED);
    boundary_s   = running_s && (cnt_r == (ratio_cur_r - ONE));
    period_end_s = !running_s || boundary_s;
    load_s       = pend_vld_r && period_end_s;
    capture_s    = ratio_req && !ratio_ack_r && !taken_r;
    ack_fall_s   = ratio_ack_r && !ratio_req;
    if (load_s) begin
      ratio_next_s = pend_ratio_r;
    end else begin
      ratio_next_s = ratio_cur_r;
    end
  end

  // Next state / counter. A period is never cut: leaving RUN with div_en=0
  // goes through DRAIN unless the disable lands exactly on the boundary.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_PARKED: begin
        cnt_next_s = ZERO;
        if (div_en) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_PARKED;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (boundary_s) begin
          cnt_next_s = ZERO;
          if (div_en) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_PARKED;
          end
        end else begin
          cnt_next_s = cnt_r + ONE;
          if (div_en) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end
      end
      default: begin
        state_next_s = ST_PARKED;
        cnt_next_s   = ZERO;
      end
    endcase
  end

  // Next output values, using the ratio that will be in effect next cycle so
  // a period that starts with a freshly loaded ratio has the right duty.
  always_comb begin
    if (state_next_s != ST_PARKED) begin
      clk_next_s  = (cnt_next_s < high_len(ratio_next_s));
      sync_next_s = (cnt_next_s == ZERO);
    end else begin
      clk_next_s  = 1'b0;
      sync_next_s = 1'b0;
    end
  end

  // Divider state, counter and registered clock outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_PARKED;
      cnt_r        <= ZERO;
      clk_out_r    <= 1'b0;
      div_sync_r   <= 1'b0;
      div_active_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      clk_out_r    <= clk_next_s;
      div_sync_r   <= sync_next_s;
      div_active_r <= (state_next_s != ST_PARKED);
    end
  end

  // Ratio request capture, load at period end, and 4-phase acknowledge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ratio_cur_r  <= DEF;
      pend_ratio_r <= DEF;
      pend_vld_r   <= 1'b0;
      loaded_r     <= 1'b0;
      taken_r      <= 1'b0;
      ratio_ack_r  <= 1'b0;
    end else begin
      ratio_cur_r <= ratio_next_s;
      loaded_r    <= load_s;
      if (capture_s) begin
        pend_ratio_r <= clamp_ratio(ratio_in);
        pend_vld_r   <= 1'b1;
        taken_r      <= 1'b1;
      end else if (load_s) begin
        pend_vld_r <= 1'b0;
      end
      if (loaded_r) begin
        ratio_ack_r <= 1'b1;
      end else if (ack_fall_s) begin
        ratio_ack_r <= 1'b0;
        taken_r     <= 1'b0;
      end
    end
  end

  assign ratio_ack  = ratio_ack_r;
  assign ratio_cur  = ratio_cur_r;
  assign clk_out    = clk_out_r;
  assign div_sync   = div_sync_r;
  assign div_active = div_active_r;

endmodule
